seq_detector_param: RTL and testbench



---
 rtl/seq_det_pkg.sv | 30 +++
 rtl/sat_counter.sv | 39 +++
 rtl/seq_detector_param.sv | 97 +++++++++
 tb/tb_seq_detector_param.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared helpers for the parametrised serial pattern detector:
// length-width sizing, pattern-length clamping and window masking.
package seq_det_pkg;

  localparam int unsigned MASK_W = 32;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

  // A zero length behaves as one bit; lengths beyond the history depth saturate.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len == 0) begin
      return 1;
    end else if (len > max_len) begin
      return max_len;
    end
    return len;
  endfunction

  function automatic logic [MASK_W-1:0] window_mask(input int unsigned len);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and registered all-ones flag.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             sat_q, sat_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && !sat_q) begin
      count_d = count_q + CNT_W'(1);
    end
    sat_d = (count_d == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      sat_q   <= sat_d;
    end
  end

  assign count = count_q;
  assign sat   = sat_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with a runtime-loadable pattern, optional
// overlapping matches, a one-cycle registered match pulse and a match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned         MAX_LEN     = 8,
  parameter int unsigned         CNT_W       = 8,
  parameter logic [MAX_LEN-1:0]  DEF_PATTERN = MAX_LEN'(8'b0000_1001),
  parameter int unsigned         DEF_LEN     = 4,
  parameter bit                  DEF_OVERLAP = 1'b1,
  localparam int unsigned        LEN_W       = len_w(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               X,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               Y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cnt_sat
);

  localparam int unsigned      FW       = LEN_W + 1;
  localparam logic [LEN_W-1:0] RST_LEN  = LEN_W'(clamp_len(DEF_LEN, MAX_LEN));
  localparam logic [LEN_W-1:0] MAX_FILL = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, hist_d, pattern_q, pattern_d;
  logic [MAX_LEN-1:0] hist_shift, win_mask;
  logic [LEN_W-1:0]   fill_q, fill_d, len_q, len_d;
  logic               overlap_q, overlap_d, y_q, y_d;
  logic               accept, full_enough, match_c;

  // Match is judged on the history as it will look after this bit shifts in.
  always_comb begin
    accept      = en & ~cfg_load;
    hist_shift  = {hist_q[MAX_LEN-2:0], X};
    win_mask    = MAX_LEN'(window_mask(32'(len_q)));
    full_enough = (FW'(fill_q) + FW'(1)) >= FW'(len_q);
    match_c     = accept & (((hist_shift ^ pattern_q) & win_mask) == '0) & full_enough;

    hist_d    = hist_q;
    fill_d    = fill_q;
    pattern_d = pattern_q;
    len_d     = len_q;
    overlap_d = overlap_q;
    y_d       = 1'b0;

    if (cfg_load) begin
      pattern_d = cfg_pattern;
      len_d     = LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
      overlap_d = cfg_overlap;
      hist_d    = '0;
      fill_d    = '0;
    end else if (accept) begin
      hist_d = hist_shift;
      fill_d = (fill_q == MAX_FILL) ? fill_q : fill_q + LEN_W'(1);
      // Non-overlapping mode: forget progress so the next match needs fresh bits.
      if (match_c && !overlap_q) fill_d = '0;
      y_d = match_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q    <= '0;
      fill_q    <= '0;
      pattern_q <= DEF_PATTERN;
      len_q     <= RST_LEN;
      overlap_q <= DEF_OVERLAP;
      y_q       <= 1'b0;
    end else begin
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      pattern_q <= pattern_d;
      len_q     <= len_d;
      overlap_q <= overlap_d;
      y_q       <= y_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match_c),
    .clr   (cfg_load),
    .count (match_cnt),
    .sat   (cnt_sat)
  );

  assign Y = y_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed vector tables plus randomized traffic
// checked against a queue-based model of the accepted bit stream.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst_n, en, x_in, cfg_load, cfg_overlap;
  logic [7:0] cfg_pattern;
  logic [3:0] cfg_len;
  logic       y_a, y_b, sat_a, sat_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .X(x_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .Y(y_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .X(x_in), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .Y(y_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
  );

  // Reference model: the accepted bits since the last clear, newest at the back.
  int         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ov;
  bit         m_y;
  int         m_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit en;
    bit x;
    bit exp_y;
    int exp_cnt;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat_of(input int c, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (c > mx) ? mx : c;
  endfunction

  task automatic model_edge();
    bit hit;
    if (!rst_n) begin
      q.delete();
      m_pat = 8'b0000_1001; m_len = 4; m_ov = 1'b1; m_y = 1'b0; m_cnt = 0;
    end else if (cfg_load) begin
      m_pat = cfg_pattern;
      m_len = (cfg_len == 0) ? 1 : (cfg_len > 8) ? 8 : int'(cfg_len);
      m_ov  = cfg_overlap;
      q.delete();
      m_y = 1'b0; m_cnt = 0;
    end else if (en) begin
      q.push_back(int'(x_in));
      if (q.size() > 8) void'(q.pop_front());
      hit = (q.size() >= m_len);
      for (int i = 0; i < m_len; i++) begin
        if (hit && q[q.size() - 1 - i] != int'(m_pat[i])) hit = 1'b0;
      end
      m_y = hit;
      if (hit) m_cnt++;
      if (hit && !m_ov) q.delete();
    end else begin
      m_y = 1'b0;
    end
  endtask

  task automatic step(input bit r, input bit e, input bit xx, input bit ld,
                      input logic [7:0] pat, input logic [3:0] len, input bit ov);
    rst_n = r; en = e; x_in = xx; cfg_load = ld;
    cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
    @(posedge clk);
    model_edge();
    #1;
    chk("y_a", y_a, m_y);
    chk("cnt_a", cnt_a, sat_of(m_cnt, 8));
    chk("sat_a", sat_a, sat_of(m_cnt, 8) == 255);
    chk("y_b", y_b, m_y);
    chk("cnt_b", cnt_b, sat_of(m_cnt, 2));
    chk("sat_b", sat_b, sat_of(m_cnt, 2) == 3);
  endtask

  task automatic bit_in(input bit e, input bit xx);
    step(1'b1, e, xx, 1'b0, 8'h00, 4'd0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'hff, 4'd2, 1'b0);
  endtask

  task automatic add(input bit e, input bit xx, input bit ey, input int ec);
    vec_t t;
    t.en = e; t.x = xx; t.exp_y = ey; t.exp_cnt = ec;
    v.push_back(t);
  endtask

  task automatic run_table(input string name);
    foreach (v[i]) begin
      bit_in(v[i].en, v[i].x);
      chk($sformatf("%s_y[%0d]", name, i), y_a, v[i].exp_y);
      chk($sformatf("%s_cnt[%0d]", name, i), cnt_a, v[i].exp_cnt);
    end
    v.delete();
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; x_in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;

    // Reset state
    do_reset();
    chk("reset_y", y_a, 0);
    chk("reset_cnt", cnt_a, 0);
    chk("reset_sat", sat_a, 0);

    // Defaults, overlapping: 1001001 matches twice
    add(1,1,0,0); add(1,0,0,0); add(1,0,0,0); add(1,1,1,1);
    add(1,0,0,1); add(1,0,0,1); add(1,1,1,2);
    run_table("ovl");

    // Same stream, non-overlapping
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'b1001, 4'd4, 1'b0);
    add(1,1,0,0); add(1,0,0,0); add(1,0,0,0); add(1,1,1,1);
    add(1,0,0,1); add(1,0,0,1); add(1,1,0,1);
    run_table("novl");

    // Defaults with en=0 gaps between accepted bits
    do_reset();
    add(1,1,0,0);
    for (int g = 0; g < 3; g++) add(0,1,0,0);
    add(1,0,0,0);
    for (int g = 0; g < 3; g++) add(0,1,0,0);
    add(1,0,0,0);
    for (int g = 0; g < 3; g++) add(0,0,0,0);
    add(1,1,1,1);
    add(0,1,0,1);
    run_table("gap");

    // Pre-load bits must not contribute; X ignored on the load cycle
    do_reset();
    bit_in(1'b1, 1'b1);
    bit_in(1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'b110, 4'd3, 1'b1);
    chk("load_y", y_a, 0);
    chk("load_cnt", cnt_a, 0);
    add(1,0,0,0); add(1,1,0,0); add(1,1,0,0); add(1,0,1,1);
    run_table("load");

    // Length 0 clamps to 1; 2-bit counter saturates at 3
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'b0000_0001, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1, 1'b1);
      chk($sformatf("len0_y[%0d]", i), y_b, 1);
      chk($sformatf("len0_cnt[%0d]", i), cnt_b, (i < 3) ? i + 1 : 3);
      chk($sformatf("len0_sat[%0d]", i), sat_b, i >= 2);
    end

    // Length above MAX_LEN clamps to 8; 8-bit counter saturates
    step(1'b1, 1'b0, 1'b0, 1'b1, 8'hff, 4'd15, 1'b1);
    for (int i = 0; i < 265; i++) bit_in(1'b1, 1'b1);
    chk("sat8_cnt", cnt_a, 255);
    chk("sat8_sat", sat_a, 1);

    // Reset mid-pattern discards partial progress
    do_reset();
    add(1,1,0,0); add(1,0,0,0); add(1,0,0,0);
    run_table("rst_pre");
    do_reset();
    add(1,1,0,0); add(1,0,0,0); add(1,0,0,0); add(1,1,1,1);
    run_table("rst_post");

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit         r, e, xx, ld, ov;
      logic [7:0] pat;
      logic [3:0] len;
      r   = ($urandom_range(0, 199) != 0);
      ld  = ($urandom_range(0, 39) == 0);
      e   = ($urandom_range(0, 9) < 7);
      xx  = 1'($urandom_range(0, 1));
      ov  = 1'($urandom_range(0, 1));
      pat = 8'($urandom);
      len = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4));
      step(r, e, xx, ld, pat, len, ov);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
